// File: rtl/mem_req_ctrl_if.sv
// Command, response, clear and memory-pin bundle for mem_req_ctrl.
// The slave side is the controller; the master side is whoever drives commands and hosts the memory.
interface mem_req_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, clr_start, mem_rdata,
        input  cmd_ready, rsp_valid, rsp_data, clr_busy, clr_done,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, clr_start, mem_rdata,
        output cmd_ready, rsp_valid, rsp_data, clr_busy, clr_done,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Sequences single read/write commands and a full-memory clear onto the strobes of a
// synchronous-read memory; read data is returned on a valid/ready response channel.
module mem_req_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_req_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RSP, CLR} state_t;

    localparam logic [1:0]        WAIT_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST  = {ADDR_W{1'b1}};

    state_t            state_reg;
    logic [1:0]        wait_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              clr_busy_reg;
    logic              clr_done_reg;

    // Ready is the only combinational output so a clear request can pre-empt a command in the same cycle.
    assign bus.cmd_ready = (state_reg == IDLE) && !bus.clr_start && !rst;
    assign bus.mem_read  = mem_read_reg;
    assign bus.mem_write = mem_write_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.clr_busy  = clr_busy_reg;
    assign bus.clr_done  = clr_done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            clr_cnt_reg   <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            clr_busy_reg  <= 1'b0;
            clr_done_reg  <= 1'b0;
        end else begin
            clr_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.clr_start) begin
                        state_reg     <= CLR;
                        clr_cnt_reg   <= '0;
                        mem_write_reg <= 1'b1;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        clr_busy_reg  <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        mem_addr_reg  <= bus.cmd_addr;
                        mem_wdata_reg <= bus.cmd_wdata;
                        if (bus.cmd_write) begin
                            mem_write_reg <= 1'b1;
                            state_reg     <= WR;
                        end else begin
                            mem_read_reg <= 1'b1;
                            state_reg    <= RD;
                        end
                    end
                end
                WR: begin
                    mem_write_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
                RD: begin
                    mem_read_reg <= 1'b0;
                    wait_cnt_reg <= '0;
                    state_reg    <= RWAIT;
                end
                RWAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        rsp_data_reg  <= bus.mem_rdata;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RSP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 2'd1;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                CLR: begin
                    // mem_addr tracks the counter so the strobe and address advance together.
                    if (clr_cnt_reg == CLR_LAST) begin
                        mem_write_reg <= 1'b0;
                        clr_busy_reg  <= 1'b0;
                        clr_done_reg  <= 1'b1;
                        clr_cnt_reg   <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        clr_cnt_reg  <= clr_cnt_reg + ADDR_W'(1);
                        mem_addr_reg <= clr_cnt_reg + ADDR_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
